a23_mem_arbiter: RTL and testbench
==================================

# a23_mem_arbiter

Two-port arbiter and access sequencer placed between the a23 core's instruction-fetch and data ports and the single shared a23 memory port. It grants one requester at a time, enforces region and byte-enable legality before any write reaches memory, and returns registered read data with a one-cycle acknowledge. Data accesses have priority; a starvation counter guarantees fetch progress.

## Interface
- STARVE_LIMIT, 4, max consecutive data grants while fetch is pending (1..15)
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_f_req  in  1  fetch request, held until o_f_ack
- i_f_address  in  32  fetch byte address, stable while i_f_req
- o_f_ack  out  1  one-cycle fetch completion pulse
- o_f_rdata  out  32  fetch read data, valid with o_f_ack, held until next ack
- i_d_req  in  1  data request, held until o_d_ack
- i_d_address  in  32  data byte address
- i_d_write  in  32  write data (byte writes use bits [7:0])
- i_d_write_en  in  1  1 = write, 0 = read
- i_d_byte_enable  in  4  byte lanes
- o_d_ack  out  1  one-cycle data completion pulse
- o_d_rdata  out  32  data read data, valid with o_d_ack
- o_d_err  out  1  access rejected, valid with o_d_ack
- o_m_address  out  32  memory address
- o_m_write  out  32  memory write data
- o_m_write_en  out  1  memory write strobe
- o_m_byte_enable  out  4  memory byte lanes
- i_m_read  in  32  memory combinational read data

## Operation
- FSM: IDLE -> ACCESS -> DONE -> IDLE. Request inputs sampled only in IDLE; ignored in ACCESS and DONE.
- IDLE: if any request, latch winner's address/data/control, go ACCESS. Winner = data, unless fetch is pending and starve count == STARVE_LIMIT, then fetch.
- Starve counter (4 bits): +1 on data grant while i_f_req high; cleared on fetch grant or any IDLE cycle with i_f_req low; saturates at STARVE_LIMIT.
- ACCESS: memory bus driven from latched request; i_m_read captured into winner's rdata register at end of cycle; o_m_write_en = latched write_en AND legal.
- DONE: winner's ack high for exactly this cycle; o_d_err driven for data.
- Legality (data writes): region = address[31:24]. Writes legal only to 8'h00, 8'h03, 8'h04. byte_enable must be 1111, 0001, 0010, 0100 or 1000. be 1111 requires address[1:0] == 0. Any violation: write suppressed, o_d_err = 1.
- Reads: region > 8'h04 -> rdata 0, o_d_err = 1 (data) / rdata 0, no error (fetch). Reads never touch byte_enable legality.
- Bus outside ACCESS: o_m_address, o_m_write, o_m_byte_enable, o_m_write_en all 0.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 (acks, err, rdata, bus).
- Request seen high in IDLE at cycle N -> bus active N+1 -> ack in N+2. Throughput: one access per 3 cycles.
- Requester must drop or change its request in the cycle after ack; a still-high request at N+3 is treated as a new access.
- Simultaneous requests: data wins, loser waits in IDLE-sampled order; with STARVE_LIMIT=4, fetch granted no later than its 5th arbitration.
- Request dropped before ack: access still completes; ack still issued.
- Reset mid-operation (ACCESS or DONE): no ack issued; a write in ACCESS is lost (memory reset also wins). Counter cleared.
- rdata registers of the non-winning port are not modified.

## Structure
- Package a23_mem_arb_pkg: state enum (IDLE, ACCESS, DONE), region constants REG_CODE=8'h00, REG_G=8'h01, REG_E=8'h02, REG_OUT=8'h03, REG_STACK=8'h04, legal byte-enable constants.
- Sub-module a23_mem_region_check: combinational (address, write_en, byte_enable) -> write_legal, read_mapped, err.

## Test plan
- Single fetch to 0x00000010 with memory returning 0xE3A00001 -> o_f_ack at N+2, o_f_rdata = 0xE3A00001, no o_m_write_en.
- Data write 0xDEADBEEF, be 1111, to 0x03000004 -> o_m_write_en high for exactly 1 cycle at N+1, o_d_ack at N+2, o_d_err 0.
- Data write be 0001 to 0x01000000 -> o_m_write_en stays 0, o_d_ack with o_d_err 1; write be 0110 to 0x04000000 -> same.
- Both requests held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- Data read at 0x05000000 -> o_d_rdata 0, o_d_err 1; fetch at same address -> rdata 0, no error.
- i_rst asserted during ACCESS of a write -> no ack, all outputs 0 next cycle, next request completes normally in 3 cycles.

Source files
------------

// File: rtl/a23_mem_arb_pkg.sv
// Shared types and constants for the a23 memory arbiter: FSM states, memory-map
// regions and the byte-enable patterns a data write may legally use.
package a23_mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } arb_state_e;

    localparam logic [7:0] REG_CODE  = 8'h00;
    localparam logic [7:0] REG_G     = 8'h01;
    localparam logic [7:0] REG_E     = 8'h02;
    localparam logic [7:0] REG_OUT   = 8'h03;
    localparam logic [7:0] REG_STACK = 8'h04;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;

    function automatic logic be_is_legal(input logic [3:0] be);
        return (be == BE_WORD) || (be == BE_B0) || (be == BE_B1) ||
               (be == BE_B2) || (be == BE_B3);
    endfunction

endpackage

// File: rtl/a23_mem_region_check.sv
// Combinational legality check of one memory access against the a23 memory map.
module a23_mem_region_check
    import a23_mem_arb_pkg::*;
(
    input  logic [31:0] address_i,
    input  logic        write_en_i,
    input  logic [3:0]  byte_enable_i,
    output logic        write_legal_o,
    output logic        read_mapped_o,
    output logic        err_o
);

    logic [7:0] region;
    logic       region_writable;
    logic       word_aligned_ok;

    always_comb begin
        region          = address_i[31:24];
        region_writable = (region == REG_CODE) || (region == REG_OUT) || (region == REG_STACK);
        // A full-word write must be word aligned; single-byte lanes carry their own offset.
        word_aligned_ok = (byte_enable_i != BE_WORD) || (address_i[1:0] == 2'b00);
        read_mapped_o   = (region == REG_CODE) || (region == REG_G) || (region == REG_E) ||
                          (region == REG_OUT) || (region == REG_STACK);
        write_legal_o   = write_en_i && region_writable && be_is_legal(byte_enable_i) &&
                          word_aligned_ok;
        err_o           = write_en_i ? !write_legal_o : !read_mapped_o;
    end

endmodule

// File: rtl/a23_mem_arbiter.sv
// Arbitrates the a23 fetch and data ports onto one memory port: data has priority,
// a starvation counter forces a fetch grant after STARVE_LIMIT consecutive data grants.
module a23_mem_arbiter
    import a23_mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_f_req,
    input  logic [31:0] i_f_address,
    output logic        o_f_ack,
    output logic [31:0] o_f_rdata,
    input  logic        i_d_req,
    input  logic [31:0] i_d_address,
    input  logic [31:0] i_d_write,
    input  logic        i_d_write_en,
    input  logic [3:0]  i_d_byte_enable,
    output logic        o_d_ack,
    output logic [31:0] o_d_rdata,
    output logic        o_d_err,
    output logic [31:0] o_m_address,
    output logic [31:0] o_m_write,
    output logic        o_m_write_en,
    output logic [3:0]  o_m_byte_enable,
    input  logic [31:0] i_m_read
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    arb_state_e  state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        data_win_q, data_win_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic fetch_win;
    logic bus_active;
    logic chk_write_legal;
    logic chk_read_mapped;
    logic chk_err;

    a23_mem_region_check u_region_check (
        .address_i     (addr_q),
        .write_en_i    (we_q),
        .byte_enable_i (be_q),
        .write_legal_o (chk_write_legal),
        .read_mapped_o (chk_read_mapped),
        .err_o         (chk_err)
    );

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        data_win_d = data_win_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        be_d       = be_q;
        f_rdata_d  = f_rdata_q;
        d_rdata_d  = d_rdata_q;
        fetch_win  = i_f_req && (!i_d_req || (starve_q == StarveMax));

        case (state_q)
            StIdle: begin
                if (!i_f_req || fetch_win) begin
                    starve_d = 4'd0;
                end else if (starve_q < StarveMax) begin
                    starve_d = starve_q + 4'd1;
                end
                if (i_f_req || i_d_req) begin
                    data_win_d = !fetch_win;
                    addr_d     = fetch_win ? i_f_address : i_d_address;
                    wdata_d    = fetch_win ? 32'd0 : i_d_write;
                    we_d       = !fetch_win && i_d_write_en;
                    be_d       = fetch_win ? BE_WORD : i_d_byte_enable;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                // Unmapped regions read as zero; only the winner's register is updated.
                if (data_win_q) begin
                    d_rdata_d = chk_read_mapped ? i_m_read : 32'd0;
                end else begin
                    f_rdata_d = chk_read_mapped ? i_m_read : 32'd0;
                end
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            starve_q   <= 4'd0;
            data_win_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            be_q       <= 4'd0;
            f_rdata_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            data_win_q <= data_win_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            be_q       <= be_d;
            f_rdata_q  <= f_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        bus_active      = (state_q == StAccess);
        o_m_address     = bus_active ? addr_q : 32'd0;
        o_m_write       = bus_active ? wdata_q : 32'd0;
        o_m_byte_enable = bus_active ? be_q : 4'd0;
        o_m_write_en    = bus_active && we_q && chk_write_legal;
        o_f_ack         = (state_q == StDone) && !data_win_q;
        o_d_ack         = (state_q == StDone) && data_win_q;
        o_d_err         = o_d_ack && chk_err;
        o_f_rdata       = f_rdata_q;
        o_d_rdata       = d_rdata_q;
    end

endmodule

// File: tb/tb_a23_mem_arbiter.sv
// Directed bench for a23_mem_arbiter with hand-computed expectations.
module tb_a23_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_we;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_read;

    int n_checks = 0;
    int n_errors = 0;

    a23_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_f_req         (f_req),
        .i_f_address     (f_addr),
        .o_f_ack         (f_ack),
        .o_f_rdata       (f_rdata),
        .i_d_req         (d_req),
        .i_d_address     (d_addr),
        .i_d_write       (d_wdata),
        .i_d_write_en    (d_we),
        .i_d_byte_enable (d_be),
        .o_d_ack         (d_ack),
        .o_d_rdata       (d_rdata),
        .o_d_err         (d_err),
        .o_m_address     (m_addr),
        .o_m_write       (m_wdata),
        .o_m_write_en    (m_we),
        .o_m_byte_enable (m_be),
        .i_m_read        (m_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " f_ack"}, 32'(f_ack), 32'd0);
        check({tag, " d_ack"}, 32'(d_ack), 32'd0);
        check({tag, " d_err"}, 32'(d_err), 32'd0);
        check({tag, " m_addr"}, m_addr, 32'd0);
        check({tag, " m_wdata"}, m_wdata, 32'd0);
        check({tag, " m_we"}, 32'(m_we), 32'd0);
        check({tag, " m_be"}, 32'(m_be), 32'd0);
    endtask

    // One complete access: request sampled at N, bus at N+1, ack at N+2, dropped after ack.
    task automatic run_access(input string tag, input logic is_d, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic we, input logic [3:0] be,
                              input logic [31:0] mval, input logic exp_we,
                              input logic [31:0] exp_rd, input logic exp_err);
        @(posedge clk);
        #1;
        m_read = mval;
        if (is_d) begin
            d_req = 1'b1; d_addr = addr; d_wdata = wdata; d_we = we; d_be = be;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, " bus addr"}, m_addr, addr);
        check({tag, " bus we"}, 32'(m_we), 32'(exp_we));
        if (exp_we) begin
            check({tag, " bus wdata"}, m_wdata, wdata);
            check({tag, " bus be"}, 32'(m_be), 32'(be));
        end
        check({tag, " early ack"}, 32'(f_ack | d_ack), 32'd0);
        @(negedge clk);
        check({tag, " f_ack"}, 32'(f_ack), 32'(!is_d));
        check({tag, " d_ack"}, 32'(d_ack), 32'(is_d));
        check({tag, " rdata"}, is_d ? d_rdata : f_rdata, exp_rd);
        check({tag, " err"}, 32'(d_err), 32'(exp_err));
        check({tag, " done we"}, 32'(m_we), 32'd0);
        check({tag, " done addr"}, m_addr, 32'd0);
        f_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check({tag, " ack gone"}, 32'(f_ack | d_ack), 32'd0);
    endtask

    logic [9:0] order;
    int         n_grants;

    initial begin
        rst = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_addr = '0;
        d_wdata = '0; d_we = 1'b0; d_be = '0; m_read = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset f_rdata", f_rdata, 32'd0);
        check("reset d_rdata", d_rdata, 32'd0);
        rst = 1'b0;

        run_access("fetch", 1'b0, 32'h0000_0010, '0, 1'b0, 4'h0,
                   32'hE3A0_0001, 1'b0, 32'hE3A0_0001, 1'b0);
        run_access("wr word", 1'b1, 32'h0300_0004, 32'hDEAD_BEEF, 1'b1, 4'b1111,
                   32'h1111_2222, 1'b1, 32'h1111_2222, 1'b0);
        run_access("wr bad region", 1'b1, 32'h0100_0000, 32'h0000_00AA, 1'b1, 4'b0001,
                   32'h3333_4444, 1'b0, 32'h3333_4444, 1'b1);
        run_access("wr bad be", 1'b1, 32'h0400_0000, 32'h0000_00BB, 1'b1, 4'b0110,
                   32'h5555_6666, 1'b0, 32'h5555_6666, 1'b1);
        run_access("wr misaligned", 1'b1, 32'h0000_0002, 32'h0102_0304, 1'b1, 4'b1111,
                   32'h0, 1'b0, 32'h0, 1'b1);
        run_access("wr byte1", 1'b1, 32'h0400_0001, 32'h0000_00CC, 1'b1, 4'b0010,
                   32'h7777_8888, 1'b1, 32'h7777_8888, 1'b0);
        run_access("rd mapped", 1'b1, 32'h0000_0020, '0, 1'b0, 4'b1111,
                   32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);
        run_access("fetch unmapped", 1'b0, 32'h0500_0000, '0, 1'b0, 4'h0,
                   32'h1234_5678, 1'b0, 32'h0, 1'b0);
        check("d_rdata untouched", d_rdata, 32'hCAFE_F00D);
        run_access("rd unmapped", 1'b1, 32'h0500_0000, '0, 1'b0, 4'b1111,
                   32'h1234_5678, 1'b0, 32'h0, 1'b1);

        // Both ports held: four data grants, then the starved fetch.
        @(posedge clk);
        #1;
        m_read = 32'h0;
        d_req = 1'b1; d_addr = 32'h0000_0100; d_we = 1'b0; d_be = 4'b1111;
        f_req = 1'b1; f_addr = 32'h0000_0200;
        order = '0;
        n_grants = 0;
        for (int c = 0; c < 40 && n_grants < 10; c++) begin
            @(negedge clk);
            if (d_ack || f_ack) begin
                order = {order[8:0], d_ack};
                n_grants++;
            end
        end
        d_req = 1'b0;
        f_req = 1'b0;
        check("starve grants", 32'(n_grants), 32'd10);
        check("starve order", 32'(order), 32'(10'b1111011110));
        repeat (3) @(negedge clk);

        // Reset while a legal write is on the bus.
        @(posedge clk);
        #1;
        d_req = 1'b1; d_addr = 32'h0300_0000; d_wdata = 32'hA5A5_A5A5; d_we = 1'b1;
        d_be = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        check("rst mid we", 32'(m_we), 32'd1);
        rst = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst mid");
        check("rst mid d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst mid no ack", 32'(d_ack | f_ack), 32'd0);
        run_access("post reset", 1'b0, 32'h0000_0040, '0, 1'b0, 4'h0,
                   32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
